// File: rtl/wisc_pipe_pkg.sv
// Shared WISC-S15 pipeline control types: hazard FSM states, register indices and bubble encodings.
// Imported by the hazard controller and by the pipeline registers that consume its bubbles.
package wisc_pipe_pkg;

  typedef enum logic [1:0] {
    HZ_RUN    = 2'd0,
    HZ_FLUSH  = 2'd1,
    HZ_FREEZE = 2'd2
  } hz_state_t;

  localparam logic [3:0] REG_R0 = 4'd0;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic reg_to_mem;
    logic branch;
    logic call;
    logic ret;
  } ex_ctrl_t;

  // What ID/EX loads when idex_flush is asserted: an instruction with no side effects.
  localparam ex_ctrl_t CTRL_BUBBLE = '0;

  function automatic logic load_use(
    input logic       mem_to_reg,
    input logic       reg_write,
    input logic [3:0] rd,
    input logic [3:0] rs1,
    input logic [3:0] rs2,
    input logic       rs1_used,
    input logic       rs2_used
  );
    return mem_to_reg && reg_write && (rd != REG_R0) &&
           ((rs1_used && (rs1 == rd)) || (rs2_used && (rs2 == rd)));
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// master = pipeline side (drives observations), slave = controller side (drives controls).
interface hazard_ctrl_if;
  logic [3:0]  id_rs1;
  logic [3:0]  id_rs2;
  logic        id_rs1_used;
  logic        id_rs2_used;
  logic [3:0]  idex_reg_rd;
  logic        idex_reg_write;
  logic        idex_mem_to_reg;
  logic        ex_redirect;
  logic        mem_busy;
  logic        pc_stall;
  logic        ifid_stall;
  logic        ifid_flush;
  logic        idex_flush;
  logic        exmem_stall;
  logic        memwb_stall;
  logic        mem_timeout;
  logic [15:0] stall_cnt;

  modport master (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used,
    output idex_reg_rd, idex_reg_write, idex_mem_to_reg,
    output ex_redirect, mem_busy,
    input  pc_stall, ifid_stall, ifid_flush, idex_flush,
    input  exmem_stall, memwb_stall, mem_timeout, stall_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used,
    input  idex_reg_rd, idex_reg_write, idex_mem_to_reg,
    input  ex_redirect, mem_busy,
    output pc_stall, ifid_stall, ifid_flush, idex_flush,
    output exmem_stall, memwb_stall, mem_timeout, stall_cnt
  );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clr wins over inc, synchronous active-low reset.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// WISC-S15 pipeline hazard controller: load-use bubbles, redirect squashing and memory freezes.
// Controls are combinational from state and inputs; priority is mem_busy > redirect/flush > load-use.
module hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MAX_WAIT     = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  hazard_ctrl_if.slave hz
);
  import wisc_pipe_pkg::*;

  localparam logic [2:0]  FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [15:0] WAIT_LAST    = 16'(MAX_WAIT - 1);

  hz_state_t   state_q, state_d;
  logic [2:0]  flush_cnt_q, flush_cnt_d;
  logic        mem_timeout_q, mem_timeout_d;

  logic        lu;
  logic        in_flush;
  logic        pc_stall;
  logic        ifid_stall;
  logic        ifid_flush;
  logic        idex_flush;
  logic        mem_hold;
  logic [15:0] wait_cnt;
  logic [15:0] stall_cnt;

  assign lu = load_use(hz.idex_mem_to_reg, hz.idex_reg_write, hz.idex_reg_rd,
                       hz.id_rs1, hz.id_rs2, hz.id_rs1_used, hz.id_rs2_used);

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    in_flush    = 1'b0;
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    mem_hold    = 1'b0;
    if (rst_n) begin
      case (state_q)
        HZ_RUN, HZ_FLUSH, HZ_FREEZE: begin
          if (hz.mem_busy) begin
            // Whole pipe holds; a pending flush count is kept and resumed on release.
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            mem_hold   = 1'b1;
            state_d    = HZ_FREEZE;
          end else begin
            in_flush = (state_q != HZ_RUN) && (flush_cnt_q != 3'd0);
            state_d  = HZ_RUN;
            if (hz.ex_redirect) begin
              ifid_flush  = 1'b1;
              idex_flush  = 1'b1;
              flush_cnt_d = FLUSH_RELOAD;
              if (FLUSH_RELOAD != 3'd0) begin
                state_d = HZ_FLUSH;
              end
            end else if (in_flush) begin
              ifid_flush  = 1'b1;
              flush_cnt_d = flush_cnt_q - 3'd1;
              if (flush_cnt_q != 3'd1) begin
                state_d = HZ_FLUSH;
              end
            end else if (lu) begin
              pc_stall   = 1'b1;
              ifid_stall = 1'b1;
              idex_flush = 1'b1;
            end
          end
        end
        default: begin
          state_d     = HZ_RUN;
          flush_cnt_d = 3'd0;
        end
      endcase
    end
  end

  // wait_cnt counts busy cycles before this one, so this cycle is busy cycle wait_cnt+1.
  assign mem_timeout_d = mem_timeout_q || (mem_hold && (wait_cnt >= WAIT_LAST));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= HZ_RUN;
      flush_cnt_q   <= 3'd0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      flush_cnt_q   <= flush_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  sat_counter #(.WIDTH(16)) u_wait_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (mem_hold),
    .clr   (!mem_hold),
    .cnt   (wait_cnt)
  );

  sat_counter #(.WIDTH(16)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pc_stall),
    .clr   (1'b0),
    .cnt   (stall_cnt)
  );

  assign hz.pc_stall    = pc_stall;
  assign hz.ifid_stall  = ifid_stall;
  assign hz.ifid_flush  = ifid_flush;
  assign hz.idex_flush  = idex_flush;
  assign hz.exmem_stall = mem_hold;
  assign hz.memwb_stall = mem_hold;
  assign hz.mem_timeout = mem_timeout_q;
  assign hz.stall_cnt   = stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a counter-based reference model.
module tb_hazard_ctrl;
  localparam int FC = 2;
  localparam int MW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if hz();

  hazard_ctrl #(.FLUSH_CYCLES(FC), .MAX_WAIT(MW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state: remaining squash cycles, consecutive busy cycles, sticky flag, stall total.
  int m_flush_left = 0;
  int m_busy_run   = 0;
  int m_stall      = 0;
  bit m_timeout    = 1'b0;
  bit started      = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] outs();
    return {hz.pc_stall, hz.ifid_stall, hz.ifid_flush, hz.idex_flush, hz.exmem_stall, hz.memwb_stall};
  endfunction

  function automatic bit model_lu();
    bit hit1, hit2;
    hit1 = hz.id_rs1_used && (hz.id_rs1 == hz.idex_reg_rd);
    hit2 = hz.id_rs2_used && (hz.id_rs2 == hz.idex_reg_rd);
    return hz.idex_mem_to_reg && hz.idex_reg_write && (hz.idex_reg_rd != 4'd0) && (hit1 || hit2);
  endfunction

  // Output order: pc_stall, ifid_stall, ifid_flush, idex_flush, exmem_stall, memwb_stall.
  function automatic logic [5:0] model_out();
    if (!rst_n)                return 6'b000000;
    if (hz.mem_busy)           return 6'b110011;
    if (m_flush_left > 0)      return {2'b00, 1'b1, hz.ex_redirect, 2'b00};
    if (hz.ex_redirect)        return 6'b001100;
    if (model_lu())            return 6'b110100;
    return 6'b000000;
  endfunction

  always @(negedge clk) begin
    logic [5:0] exp_o;
    exp_o = model_out();
    if (started) begin
      check("ctrl", 32'(outs()), 32'(exp_o));
      check("stall_cnt", 32'(hz.stall_cnt), m_stall);
      check("mem_timeout", 32'(hz.mem_timeout), 32'(m_timeout));
    end
    if (!rst_n) begin
      m_flush_left = 0;
      m_busy_run   = 0;
      m_stall      = 0;
      m_timeout    = 1'b0;
      started      = 1'b1;
    end else begin
      if (exp_o[5] && m_stall < 65535) m_stall++;
      if (hz.mem_busy) begin
        if (m_busy_run < 65535) m_busy_run++;
        if (m_busy_run >= MW) m_timeout = 1'b1;
      end else begin
        m_busy_run = 0;
        if (hz.ex_redirect)        m_flush_left = FC - 1;
        else if (m_flush_left > 0) m_flush_left--;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit busy, input bit redir, input bit mtr, input bit rw,
                       input logic [3:0] rd, input logic [3:0] rs1, input logic [3:0] rs2,
                       input bit u1, input bit u2);
    hz.mem_busy        = busy;
    hz.ex_redirect     = redir;
    hz.idex_mem_to_reg = mtr;
    hz.idex_reg_write  = rw;
    hz.idex_reg_rd     = rd;
    hz.id_rs1          = rs1;
    hz.id_rs2          = rs2;
    hz.id_rs1_used     = u1;
    hz.id_rs2_used     = u2;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0);
  endtask

  initial begin
    int busy_left;
    busy_left = 0;
    rst_n = 1'b0;
    idle();
    tick();
    tick();
    check("reset_ctrl", 32'(outs()), 0);
    check("reset_cnt", 32'(hz.stall_cnt), 0);
    check("reset_timeout", 32'(hz.mem_timeout), 0);
    rst_n = 1'b1;
    tick();

    // Load-use on rs2: one bubble, then the load has moved on.
    drive(0, 0, 1, 1, 4'd5, 4'd0, 4'd5, 0, 1); #2;
    check("lu_ctrl", 32'(outs()), 32'(6'b110100));
    check("lu_cnt_before", 32'(hz.stall_cnt), 0);
    tick(); idle(); #2;
    check("lu_cleared", 32'(outs()), 0);
    check("lu_cnt_after", 32'(hz.stall_cnt), 1);

    tick(); drive(0, 0, 1, 1, 4'd0, 4'd0, 4'd7, 1, 0); #2;
    check("r0_no_hazard", 32'(outs()), 0);
    tick(); drive(0, 0, 1, 1, 4'd3, 4'd3, 4'd7, 0, 0); #2;
    check("unused_src", 32'(outs()), 0);

    tick(); drive(0, 1, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0); #2;
    check("redir_c0", 32'(outs()), 32'(6'b001100));
    tick(); idle(); #2;
    check("redir_c1", 32'(outs()), 32'(6'b001000));
    tick(); idle(); #2;
    check("redir_c2", 32'(outs()), 0);

    tick(); drive(1, 1, 1, 1, 4'd5, 4'd0, 4'd5, 0, 1); #2;
    check("prio_busy", 32'(outs()), 32'(6'b110011));
    tick(); drive(0, 1, 1, 1, 4'd5, 4'd0, 4'd5, 0, 1); #2;
    check("prio_release", 32'(outs()), 32'(6'b001100));
    tick(); idle(); #2;
    check("prio_flush", 32'(outs()), 32'(6'b001000));
    tick(); idle();

    // Watchdog: timeout becomes visible after the 4th consecutive busy edge.
    for (int i = 1; i <= 6; i++) begin
      tick(); drive(1, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0); #2;
      check("wd_busy_timeout", 32'(hz.mem_timeout), (i >= 5) ? 1 : 0);
    end
    tick(); idle(); #2;
    check("wd_sticky", 32'(hz.mem_timeout), 1);
    check("wd_released", 32'(outs()), 0);

    // Reset while squashing.
    tick(); drive(0, 1, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0);
    tick(); idle(); #2;
    check("flush_before_rst", 32'(outs()), 32'(6'b001000));
    rst_n = 1'b0; #1;
    check("rst_forces_zero", 32'(outs()), 0);
    tick(); rst_n = 1'b1; #2;
    check("post_rst_ctrl", 32'(outs()), 0);
    check("post_rst_cnt", 32'(hz.stall_cnt), 0);
    check("post_rst_timeout", 32'(hz.mem_timeout), 0);

    // Drive stall_cnt into saturation with a long freeze.
    tick(); drive(1, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0);
    repeat (65540) tick();
    #2;
    check("sat_reach", 32'(hz.stall_cnt), 32'h0000FFFF);
    tick(); #2;
    check("sat_hold", 32'(hz.stall_cnt), 32'h0000FFFF);
    rst_n = 1'b0;
    tick(); rst_n = 1'b1; idle(); #2;
    check("sat_rst", 32'(hz.stall_cnt), 0);

    repeat (3000) begin
      bit busy;
      tick();
      if (busy_left > 0) begin
        busy = 1'b1;
        busy_left--;
      end else begin
        busy = ($urandom_range(0, 7) == 0);
        if (busy) busy_left = $urandom_range(0, 6);
      end
      drive(busy, ($urandom_range(0, 6) == 0), 1'($urandom), ($urandom_range(0, 3) != 0),
            4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom));
      rst_n = ($urandom_range(0, 199) != 0);
    end
    tick();
    rst_n = 1'b1;
    idle();
    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
